// File: rtl/delay_input_sequencer.sv
// Double-buffered channel collector: writes fill one bank while the other drains one word/cycle.
// step_start at T -> sta high T+2..T+1+N_CH; no backpressure, early step_start is dropped and flagged.
module delay_input_sequencer #(
  parameter int N_CH = 16,
  parameter int DW   = 32,
  parameter int AW   = 12
) (
  input  logic          clk,
  input  logic          rst_user,
  input  logic          step_start,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_ch,
  input  logic [DW-1:0] wr_data,
  output logic          sta,
  output logic [DW-1:0] x,
  output logic [AW-1:0] ch_idx,
  output logic          busy,
  output logic          overrun,
  output logic          missing
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [AW-1:0] LAST = AW'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   x_q, x_d;
  logic            fill_q;
  logic            overrun_q, missing_q;
  logic [DW-1:0]   mem_q  [2][N_CH];
  logic [N_CH-1:0] vld_q  [2];
  logic [DW-1:0]   hold_q [N_CH];

  logic            drain, wr_ok, accept;
  logic [CW-1:0]   wr_idx, cur_idx, rd_idx;
  logic [AW-1:0]   cnt_inc;
  logic [DW-1:0]   rd_word;

  assign drain   = ~fill_q;
  // Compare in AW+1 bits so N_CH == 2**AW does not wrap to zero.
  assign wr_ok   = wr_en && ({1'b0, wr_ch} < (AW + 1)'(N_CH));
  assign accept  = step_start && (state_q == IDLE);
  assign wr_idx  = wr_ch[CW-1:0];
  assign cur_idx = cnt_q[CW-1:0];
  assign cnt_inc = cnt_q + AW'(1);
  assign rd_idx  = (state_q == LOAD) ? '0 : cnt_inc[CW-1:0];
  assign rd_word = vld_q[drain][rd_idx] ? mem_q[drain][rd_idx] : hold_q[rd_idx];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    case (state_q)
      IDLE: if (step_start) state_d = LOAD;
      LOAD: begin
        state_d = EMIT;
        cnt_d   = '0;
        x_d     = rd_word;
      end
      EMIT: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
          x_d   = rd_word;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_user) begin
    if (rst_user) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      x_q       <= '0;
      fill_q    <= 1'b0;
      overrun_q <= 1'b0;
      missing_q <= 1'b0;
      vld_q[0]  <= '0;
      vld_q[1]  <= '0;
      for (int i = 0; i < N_CH; i++) hold_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      if (step_start && (state_q != IDLE)) overrun_q <= 1'b1;
      // A write alongside an accepted step_start still hits the bank being frozen.
      if (wr_ok) vld_q[fill_q][wr_idx] <= 1'b1;
      if (accept) begin
        fill_q       <= ~fill_q;
        vld_q[drain] <= '0;
      end
      if (state_q == EMIT) begin
        if (vld_q[drain][cur_idx]) hold_q[cur_idx] <= x_q;
        else                       missing_q       <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[fill_q][wr_idx] <= wr_data;
  end

  assign sta     = (state_q == EMIT);
  assign x       = x_q;
  assign ch_idx  = cnt_q;
  assign busy    = (state_q != IDLE);
  assign overrun = overrun_q;
  assign missing = missing_q;

endmodule

// File: tb/tb_delay_input_sequencer.sv
// Randomized bench for delay_input_sequencer: a step-level model predicts each burst into a
// scoreboard queue, a negedge monitor compares every cycle's sta/x/ch_idx against it.
module tb_delay_input_sequencer;
  localparam int N_CH = 4;
  localparam int DW   = 32;
  localparam int AW   = 12;

  logic          clk = 1'b0;
  logic          rst_user = 1'b1;
  logic          step_start = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_ch = '0;
  logic [DW-1:0] wr_data = '0;
  logic          sta, busy, overrun, missing;
  logic [DW-1:0] x;
  logic [AW-1:0] ch_idx;

  delay_input_sequencer #(.N_CH(N_CH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_user(rst_user), .step_start(step_start), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_data(wr_data), .sta(sta), .x(x), .ch_idx(ch_idx),
    .busy(busy), .overrun(overrun), .missing(missing)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   at;
    logic [AW-1:0] ch;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t          q[$];
  exp_t          mon_e;
  int unsigned   edge_n = 0;
  int unsigned   busy_end = 0;
  int            n_chk = 0;
  int            n_fail = 0;
  bit            f_vld [N_CH];
  logic [DW-1:0] f_dat [N_CH];
  logic [DW-1:0] hold  [N_CH];
  bit            m_overrun, m_missing;
  logic [DW-1:0] last_x;
  logic [AW-1:0] last_ch;

  always @(posedge clk) edge_n++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Each negedge: sta must match the scoreboard, and x/ch_idx either match the popped word or hold.
  always @(negedge clk) begin
    if (!rst_user) begin
      if (q.size() > 0 && q[0].at == edge_n) begin
        mon_e = q.pop_front();
        chk("sta", {63'd0, sta}, 64'd1);
        chk("x", {32'd0, x}, {32'd0, mon_e.dat});
        chk("ch_idx", {52'd0, ch_idx}, {52'd0, mon_e.ch});
        last_x  = mon_e.dat;
        last_ch = mon_e.ch;
      end else begin
        chk("sta_idle", {63'd0, sta}, 64'd0);
        chk("x_hold", {32'd0, x}, {32'd0, last_x});
        chk("ch_hold", {52'd0, ch_idx}, {52'd0, last_ch});
      end
    end
  end

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < N_CH; i++) begin
      f_vld[i] = 1'b0;
      f_dat[i] = '0;
      hold[i]  = '0;
    end
    m_overrun = 1'b0;
    m_missing = 1'b0;
    last_x    = '0;
    last_ch   = '0;
    busy_end  = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_sta", {63'd0, sta}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_x", {32'd0, x}, 64'd0);
    chk("rst_ch_idx", {52'd0, ch_idx}, 64'd0);
    chk("rst_overrun", {63'd0, overrun}, 64'd0);
    chk("rst_missing", {63'd0, missing}, 64'd0);
  endtask

  task automatic do_reset();
    rst_user = 1'b1;
    #1;
    model_clear();
    chk_reset_outputs();
    @(posedge clk); #1;
    rst_user = 1'b0;
  endtask

  // Drive one cycle; the model decides acceptance from the step timeline, not DUT state.
  task automatic cyc(input bit st, input bit we, input logic [AW-1:0] ch, input logic [DW-1:0] d);
    int unsigned k;
    logic [DW-1:0] v;
    step_start = st;
    wr_en      = we;
    wr_ch      = ch;
    wr_data    = d;
    k = edge_n + 1;
    if (we && ch < N_CH) begin
      f_vld[ch] = 1'b1;
      f_dat[ch] = d;
    end
    if (st) begin
      if (k > busy_end) begin
        for (int i = 0; i < N_CH; i++) begin
          v = f_vld[i] ? f_dat[i] : hold[i];
          if (!f_vld[i]) m_missing = 1'b1;
          hold[i] = v;
          q.push_back('{k + 1 + i, AW'(i), v});
          f_vld[i] = 1'b0;
        end
        busy_end = k + N_CH + 1;
      end else begin
        m_overrun = 1'b1;
      end
    end
    @(posedge clk); #1;
    step_start = 1'b0;
    wr_en      = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 50) begin
      cyc(0, 0, '0, '0);
      n++;
    end
    chk("drain_left", 64'(q.size()), 64'd0);
    cyc(0, 0, '0, '0);
    chk("busy_after", {63'd0, busy}, 64'd0);
    chk("overrun", {63'd0, overrun}, {63'd0, m_overrun});
    chk("missing", {63'd0, missing}, {63'd0, m_missing});
  endtask

  initial begin
    model_clear();
    #1;
    chk_reset_outputs();
    @(posedge clk); #1;
    rst_user = 1'b0;
    cyc(0, 0, '0, '0);

    cyc(0, 1, 12'd0, 32'h3F800000);
    cyc(0, 1, 12'd1, 32'h40000000);
    cyc(0, 1, 12'd2, 32'h40400000);
    cyc(0, 1, 12'd3, 32'h40800000);
    cyc(1, 0, '0, '0);
    drain();

    cyc(0, 1, 12'd2, 32'h41000000);
    cyc(1, 0, '0, '0);
    drain();

    cyc(1, 0, '0, '0);
    cyc(0, 0, '0, '0);
    cyc(0, 0, '0, '0);
    cyc(1, 0, '0, '0);
    drain();

    cyc(1, 1, 12'd1, 32'h42000000);
    drain();

    cyc(0, 1, 12'd7, 32'hDEADBEEF);
    cyc(1, 0, '0, '0);
    cyc(0, 0, '0, '0);
    cyc(0, 0, '0, '0);
    do_reset();
    for (int i = 0; i < 8; i++) cyc(0, 0, '0, '0);

    // Steps right after reset drain the cleared hold registers.
    cyc(1, 0, '0, '0);
    drain();

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
          AW'($urandom_range(0, 7)), $urandom);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
